// File: rtl/rw_writeback.sv
// rw_writeback: register-writeback stage of the RISC pipeline.
// Decodes the instruction leaving MA, commits its result into a 32 x DATA_W register file
// (r0 hardwired to zero), serves two combinational read ports with same-cycle write bypass,
// counts retired instructions and freezes architectural state once a HALT retires.
//
// Ports:
//   clk, rst_n      pipeline clock (posedge), asynchronous active-low reset
//   Data_In         result from MA/RW register (ALU result or load data)
//   Inst_In         instruction from MA/RW register; 32'd0 is a bubble
//   Rs1_Addr/Data   read port 1 (data combinational)
//   Rs2_Addr/Data   read port 2 (data combinational)
//   Wr_En/Addr/Data write that commits at the next posedge (combinational, for forwarding)
//   Halted          registered RUN/HALTED state
//   Retired_Count   registered retired-instruction counter, wraps modulo 2^CNT_W
module rw_writeback #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] Data_In,
  input  logic [31:0]       Inst_In,
  input  logic [4:0]        Rs1_Addr,
  input  logic [4:0]        Rs2_Addr,
  output logic [DATA_W-1:0] Rs1_Data,
  output logic [DATA_W-1:0] Rs2_Data,
  output logic              Wr_En,
  output logic [4:0]        Wr_Addr,
  output logic [DATA_W-1:0] Wr_Data,
  output logic              Halted,
  output logic [CNT_W-1:0]  Retired_Count
);

  typedef enum logic [0:0] {StRun, StHalted} state_e;

  localparam logic [5:0] OpLoad = 6'b010000;
  localparam logic [5:0] OpHalt = 6'b111111;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rf_q [1:31];

  logic [5:0] opcode;
  logic [4:0] rd;
  logic       writes_class;
  logic       retire;

  assign opcode = Inst_In[31:26];
  assign rd     = Inst_In[25:21];

  // A bubble decodes as ALU with rd=0, so it never writes.
  assign writes_class = (opcode[5:4] == 2'b00) || (opcode == OpLoad);
  assign retire       = (state_q == StRun) && (Inst_In != 32'd0);

  assign Wr_En         = (state_q == StRun) && writes_class && (rd != 5'd0);
  assign Wr_Addr       = rd;
  assign Wr_Data       = Data_In;
  assign Halted        = (state_q == StHalted);
  assign Retired_Count = cnt_q;

  // Next-state and counter logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StRun: begin
        if (retire) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (opcode == OpHalt) begin
            state_d = StHalted;
          end
        end
      end
      StHalted: begin
        state_d = StHalted;
      end
      default: begin
        state_d = StRun;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StRun;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < 32; i++) begin
        rf_q[i] <= '0;
      end
    end else if (Wr_En) begin
      rf_q[rd] <= Data_In;
    end
  end

  // Read ports: r0 is zero, then the in-flight write wins over the stored value.
  always_comb begin
    Rs1_Data = '0;
    if (Rs1_Addr != 5'd0) begin
      if (Wr_En && (Wr_Addr == Rs1_Addr)) begin
        Rs1_Data = Data_In;
      end else begin
        Rs1_Data = rf_q[Rs1_Addr];
      end
    end
  end

  always_comb begin
    Rs2_Data = '0;
    if (Rs2_Addr != 5'd0) begin
      if (Wr_En && (Wr_Addr == Rs2_Addr)) begin
        Rs2_Data = Data_In;
      end else begin
        Rs2_Data = rf_q[Rs2_Addr];
      end
    end
  end

endmodule

// File: tb/tb_rw_writeback.sv
// Scoreboard bench for rw_writeback. Stimulus pushes expected values into a queue; a monitor
// on the falling edge pops and compares them against the DUT outputs. A second instance with
// CNT_W=4 shares all inputs so the counter wrap can be observed quickly.
module tb_rw_writeback;

  logic        clk;
  logic        rst_n;
  logic [31:0] Data_In;
  logic [31:0] Inst_In;
  logic [4:0]  Rs1_Addr;
  logic [4:0]  Rs2_Addr;
  logic [31:0] Rs1_Data, Rs2_Data, Wr_Data;
  logic        Wr_En, Halted;
  logic [4:0]  Wr_Addr;
  logic [31:0] Retired_Count;
  logic [31:0] Rs1_Data4, Rs2_Data4, Wr_Data4;
  logic        Wr_En4, Halted4;
  logic [4:0]  Wr_Addr4;
  logic [3:0]  Retired_Count4;

  rw_writeback #(.DATA_W(32), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .Data_In(Data_In), .Inst_In(Inst_In),
    .Rs1_Addr(Rs1_Addr), .Rs2_Addr(Rs2_Addr), .Rs1_Data(Rs1_Data), .Rs2_Data(Rs2_Data),
    .Wr_En(Wr_En), .Wr_Addr(Wr_Addr), .Wr_Data(Wr_Data), .Halted(Halted),
    .Retired_Count(Retired_Count)
  );

  rw_writeback #(.DATA_W(32), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .Data_In(Data_In), .Inst_In(Inst_In),
    .Rs1_Addr(Rs1_Addr), .Rs2_Addr(Rs2_Addr), .Rs1_Data(Rs1_Data4), .Rs2_Data(Rs2_Data4),
    .Wr_En(Wr_En4), .Wr_Addr(Wr_Addr4), .Wr_Data(Wr_Data4), .Halted(Halted4),
    .Retired_Count(Retired_Count4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int SelRs1 = 0, SelRs2 = 1, SelWrEn = 2, SelHalt = 3, SelCnt = 4, SelCnt4 = 5,
                 SelWrAddr = 6, SelWrData = 7;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } item_t;

  item_t q[$];
  int    checks = 0;
  int    passed = 0;

  // Bench model of the registered outputs.
  int   cnt_m = 0;
  logic halted_m = 1'b0;

  always @(negedge clk) begin
    item_t       it;
    logic [31:0] act;
    while (q.size() > 0) begin
      it = q.pop_front();
      case (it.sel)
        SelRs1:    act = Rs1_Data;
        SelRs2:    act = Rs2_Data;
        SelWrEn:   act = {31'd0, Wr_En};
        SelHalt:   act = {31'd0, Halted};
        SelCnt:    act = Retired_Count;
        SelCnt4:   act = {28'd0, Retired_Count4};
        SelWrAddr: act = {27'd0, Wr_Addr};
        default:   act = Wr_Data;
      endcase
      checks++;
      if (act === it.exp) begin
        passed++;
      end else begin
        $display("FAIL %s: got %h expected %h at %0t", it.name, act, it.exp, $time);
      end
    end
  end

  function automatic void expect_v(input string name, input int sel, input logic [31:0] exp);
    item_t it;
    it.name = name;
    it.sel  = sel;
    it.exp  = exp;
    q.push_back(it);
  endfunction

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rd);
    return {op, rd, 21'd0};
  endfunction

  task automatic drive(input logic [31:0] inst, input logic [31:0] data,
                       input logic [4:0] a1, input logic [4:0] a2);
    Inst_In  = inst;
    Data_In  = data;
    Rs1_Addr = a1;
    Rs2_Addr = a2;
  endtask

  // Pushes registered-output expectations, advances one cycle, then updates the model.
  task automatic tick();
    expect_v("halted", SelHalt, {31'd0, halted_m});
    expect_v("retired_count", SelCnt, 32'(cnt_m));
    expect_v("retired_count4", SelCnt4, 32'(cnt_m % 16));
    @(posedge clk);
    #1;
    if (!halted_m && Inst_In != 32'd0) begin
      cnt_m++;
      if (Inst_In[31:26] == 6'b111111) halted_m = 1'b1;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    drive(32'd0, 32'd0, 5'd0, 5'd0);
    #23;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset contents: every address reads zero on both ports.
    for (int a = 0; a < 32; a++) begin
      drive(32'd0, 32'hFFFF_FFFF, 5'(a), 5'(31 - a));
      expect_v("rst_rs1", SelRs1, 32'd0);
      expect_v("rst_rs2", SelRs2, 32'd0);
      if (a == 0) expect_v("bubble_wr_en", SelWrEn, 32'd0);
      tick();
    end

    // ALU rd=5 with bypass on both ports.
    drive(mk(6'b000000, 5'd5), 32'hDEADBEEF, 5'd5, 5'd5);
    expect_v("alu_wr_en", SelWrEn, 32'd1);
    expect_v("alu_wr_addr", SelWrAddr, 32'd5);
    expect_v("alu_wr_data", SelWrData, 32'hDEADBEEF);
    expect_v("bypass_rs1", SelRs1, 32'hDEADBEEF);
    expect_v("bypass_rs2", SelRs2, 32'hDEADBEEF);
    tick();
    drive(32'd0, 32'h0, 5'd5, 5'd4);
    expect_v("rf_r5", SelRs1, 32'hDEADBEEF);
    expect_v("rf_r4", SelRs2, 32'd0);
    tick();

    // Write to r0 dropped; STORE does not write.
    drive(mk(6'b000001, 5'd0), 32'h1234, 5'd0, 5'd0);
    expect_v("r0_wr_en", SelWrEn, 32'd0);
    expect_v("r0_read", SelRs1, 32'd0);
    tick();
    drive(mk(6'b010001, 5'd7), 32'h7777, 5'd7, 5'd0);
    expect_v("store_wr_en", SelWrEn, 32'd0);
    expect_v("store_rs1", SelRs1, 32'd0);
    tick();
    drive(32'd0, 32'h0, 5'd7, 5'd0);
    expect_v("r7_after_store", SelRs1, 32'd0);
    tick();

    // Immediate-class write, then branch (no write) reading it back from the regfile.
    drive(mk(6'b001010, 5'd9), 32'h9999, 5'd9, 5'd5);
    expect_v("imm_wr_en", SelWrEn, 32'd1);
    expect_v("imm_bypass", SelRs1, 32'h9999);
    expect_v("imm_other_port", SelRs2, 32'hDEADBEEF);
    tick();
    drive(mk(6'b100101, 5'd9), 32'h0, 5'd5, 5'd9);
    expect_v("branch_wr_en", SelWrEn, 32'd0);
    expect_v("branch_rs2", SelRs2, 32'h9999);
    tick();
    drive(mk(6'b110000, 5'd9), 32'h1, 5'd0, 5'd9);
    expect_v("other_op_wr_en", SelWrEn, 32'd0);
    expect_v("other_op_rs2", SelRs2, 32'h9999);
    tick();

    // Enough retires to take the 4-bit counter through its wrap.
    for (int i = 0; i < 20; i++) begin
      drive(mk(6'b000011, 5'd10), 32'(i + 100), 5'd10, 5'd10);
      expect_v("loop_bypass", SelRs1, 32'(i + 100));
      tick();
    end

    // LOAD r3, HALT, then an ALU write to r3 that must be ignored.
    drive(mk(6'b010000, 5'd3), 32'h55, 5'd3, 5'd0);
    expect_v("load_wr_en", SelWrEn, 32'd1);
    expect_v("load_bypass", SelRs1, 32'h55);
    tick();
    drive(mk(6'b111111, 5'd3), 32'h66, 5'd3, 5'd0);
    expect_v("halt_wr_en", SelWrEn, 32'd0);
    expect_v("halt_rs1", SelRs1, 32'h55);
    tick();
    drive(mk(6'b000000, 5'd3), 32'hAA, 5'd3, 5'd3);
    expect_v("halted_wr_en", SelWrEn, 32'd0);
    expect_v("halted_no_bypass", SelRs1, 32'h55);
    tick();
    drive(32'd0, 32'h0, 5'd3, 5'd10);
    expect_v("halted_r3", SelRs1, 32'h55);
    expect_v("halted_r10", SelRs2, 32'd119);
    tick();

    // Asynchronous reset between edges while halted; held across a posedge.
    #2;
    rst_n = 1'b0;
    cnt_m    = 0;
    halted_m = 1'b0;
    expect_v("reset_r3", SelRs1, 32'd0);
    expect_v("reset_r10", SelRs2, 32'd0);
    expect_v("reset_halted", SelHalt, 32'd0);
    expect_v("reset_count", SelCnt, 32'd0);
    @(posedge clk);
    drive(mk(6'b000000, 5'd3), 32'hAA, 5'd0, 5'd0);
    expect_v("reset_held_count", SelCnt, 32'd0);
    expect_v("reset_held_halted", SelHalt, 32'd0);
    @(negedge clk);
    #1;
    drive(32'd0, 32'h0, 5'd3, 5'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    drive(mk(6'b000000, 5'd3), 32'hAA, 5'd3, 5'd0);
    expect_v("post_reset_wr_en", SelWrEn, 32'd1);
    tick();
    drive(32'd0, 32'h0, 5'd3, 5'd0);
    expect_v("post_reset_r3", SelRs1, 32'hAA);
    tick();

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      checks++;
      $display("FAIL scoreboard_drain: got %0d pending entries expected 0", q.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
